// File: rtl/calc_pkg.sv
// Shared definitions for the RPN calculator: operand-stack op codes and the
// default stack geometry used by both the controller and calc_stack.
package calc_pkg;

  localparam int CALC_WIDTH = 32;
  localparam int CALC_DEPTH = 16;
  localparam int CALC_CNTW  = 6;

  typedef enum logic [2:0] {
    OP_NONE    = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_REPLACE = 3'd3,
    OP_CLEAR   = 3'd4
  } stack_op_e;

endpackage

// File: rtl/stack_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, two asynchronous
// read ports for the top and next-to-top entries. Contents are not reset.
module stack_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    top_addr,
  input  logic [AW-1:0]    next_addr,
  output logic [WIDTH-1:0] top_data,
  output logic [WIDTH-1:0] next_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign top_data  = mem[top_addr];
  assign next_data = mem[next_addr];

endmodule

// File: rtl/calc_stack.sv
// LIFO operand stack for the RPN controller: op decode, occupancy count and
// overflow/underflow error flags around a stack_mem register array.
module calc_stack
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH,
  parameter int DEPTH = CALC_DEPTH,
  parameter int CNTW  = CALC_CNTW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] stack_top,
  output logic [WIDTH-1:0] stack_next,
  output logic [CNTW-1:0]  numcnt,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);

  // Handshake: push, pop and clear are level strobes with no ready. Every
  // cycle a strobe is high is one operation; the stack always accepts and
  // reports a dropped op through overflow/underflow one cycle later.

  logic [CNTW-1:0]  count, count_nxt;
  logic             ovf_nxt, unf_nxt, err_nxt;
  logic             we;
  logic [AW-1:0]    waddr, top_addr, next_addr;
  logic [WIDTH-1:0] top_data, next_data;
  stack_op_e        op;

  assign full      = (count == CNTW'(DEPTH));
  assign empty     = (count == '0);
  assign top_addr  = count[AW-1:0] - AW'(1);
  assign next_addr = count[AW-1:0] - AW'(2);

  always_comb begin
    op = OP_NONE;
    if (clear)             op = OP_CLEAR;
    else if (push && pop)  op = OP_REPLACE;
    else if (push)         op = OP_PUSH;
    else if (pop)          op = OP_POP;
  end

  always_comb begin
    count_nxt = count;
    we        = 1'b0;
    waddr     = top_addr;
    ovf_nxt   = 1'b0;
    unf_nxt   = 1'b0;
    case (op)
      OP_PUSH: begin
        if (full) ovf_nxt = 1'b1;
        else begin
          we        = 1'b1;
          waddr     = count[AW-1:0];
          count_nxt = count + CNTW'(1);
        end
      end
      OP_POP: begin
        if (empty) unf_nxt = 1'b1;
        else       count_nxt = count - CNTW'(1);
      end
      OP_REPLACE: begin
        we = 1'b1;
        // On an empty stack the push half still lands; only the pop faults.
        if (empty) begin
          waddr     = '0;
          count_nxt = CNTW'(1);
          unf_nxt   = 1'b1;
        end
      end
      OP_CLEAR: count_nxt = '0;
      default: ;
    endcase
    err_nxt = (op == OP_CLEAR) ? 1'b0 : (err | ovf_nxt | unf_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      err       <= 1'b0;
    end else begin
      count     <= count_nxt;
      overflow  <= ovf_nxt;
      underflow <= unf_nxt;
      err       <= err_nxt;
    end
  end

  stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk       (clk),
    .we        (we && !rst),
    .waddr     (waddr),
    .wdata     (data_in),
    .top_addr  (top_addr),
    .next_addr (next_addr),
    .top_data  (top_data),
    .next_data (next_data)
  );

  assign numcnt     = count;
  assign stack_top  = (count >= CNTW'(1)) ? top_data  : '0;
  assign stack_next = (count >= CNTW'(2)) ? next_data : '0;

endmodule

// File: tb/tb_calc_stack.sv
// Bench for calc_stack: directed scenarios plus a randomized run checked
// against a queue-based LIFO model.
module tb_calc_stack;

  localparam int W = 32;
  localparam int D = 16;
  localparam int C = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clear = 1'b0, push = 1'b0, pop = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] stack_top, stack_next;
  logic [C-1:0] numcnt;
  logic         full, empty, overflow, underflow, err;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: the stack contents as a queue, top at the back.
  logic [W-1:0] exp_q[$];
  logic         m_err = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

  calc_stack #(.WIDTH(W), .DEPTH(D), .CNTW(C)) dut (
    .clk(clk), .rst(rst), .clear(clear), .push(push), .pop(pop),
    .data_in(data_in), .stack_top(stack_top), .stack_next(stack_next),
    .numcnt(numcnt), .full(full), .empty(empty), .overflow(overflow),
    .underflow(underflow), .err(err)
  );

  always #5 clk = ~clk;

  task automatic model_apply(input logic c, input logic p, input logic o,
                             input logic [W-1:0] d);
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (c) begin
      exp_q.delete();
      m_err = 1'b0;
      return;
    end
    if (p && o) begin
      if (exp_q.size() >= 1) exp_q[exp_q.size()-1] = d;
      else begin exp_q.push_back(d); m_unf = 1'b1; end
    end else if (p) begin
      if (exp_q.size() < D) exp_q.push_back(d);
      else m_ovf = 1'b1;
    end else if (o) begin
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      else m_unf = 1'b1;
    end
    m_err = m_err | m_ovf | m_unf;
  endtask

  // One clocked operation; outputs are valid for checking on return.
  task automatic do_op(input logic c, input logic p, input logic o,
                       input logic [W-1:0] d);
    clear = c; push = p; pop = o; data_in = d;
    @(posedge clk);
    #1;
    model_apply(c, p, o, d);
    clear = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (stack_top !== '0) begin tests_failed++; $display("FAIL reset_top: got %h want 0", stack_top); end
    tests_run++; if (stack_next !== '0) begin tests_failed++; $display("FAIL reset_next: got %h want 0", stack_next); end
    tests_run++; if (numcnt !== '0) begin tests_failed++; $display("FAIL reset_numcnt: got %0d want 0", numcnt); end
    tests_run++; if ({empty, full, overflow, underflow, err} !== 5'b10000) begin tests_failed++; $display("FAIL reset_flags: got %b want 10000", {empty, full, overflow, underflow, err}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_push_pop;
    do_op(0, 1, 0, 32'h1234);
    do_op(0, 1, 0, 32'h00AB);
    tests_run++; if (stack_top !== 32'h00AB) begin tests_failed++; $display("FAIL pp_top: got %h want 000000ab", stack_top); end
    tests_run++; if (stack_next !== 32'h1234) begin tests_failed++; $display("FAIL pp_next: got %h want 00001234", stack_next); end
    tests_run++; if (numcnt !== 6'd2 || empty !== 1'b0) begin tests_failed++; $display("FAIL pp_cnt: got %0d/%b want 2/0", numcnt, empty); end
    do_op(0, 0, 1, '0);
    tests_run++; if (stack_top !== 32'h1234 || stack_next !== '0 || numcnt !== 6'd1) begin tests_failed++; $display("FAIL pop1: got %h %h %0d want 1234 0 1", stack_top, stack_next, numcnt); end
    do_op(0, 0, 1, '0);
    tests_run++; if (stack_top !== '0 || empty !== 1'b1) begin tests_failed++; $display("FAIL pop2: got %h %b want 0 1", stack_top, empty); end
    do_op(0, 0, 1, '0);
    tests_run++; if (underflow !== 1'b1 || err !== 1'b1 || numcnt !== '0) begin tests_failed++; $display("FAIL underflow: got unf=%b err=%b cnt=%0d want 1 1 0", underflow, err, numcnt); end
    do_op(0, 0, 0, '0);
    tests_run++; if (underflow !== 1'b0 || err !== 1'b1) begin tests_failed++; $display("FAIL unf_pulse: got unf=%b err=%b want 0 1", underflow, err); end
  endtask

  task automatic test_overflow;
    do_op(1, 0, 0, '0);
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL clear_err: got %b want 0", err); end
    for (int i = 1; i <= D; i++) do_op(0, 1, 0, W'(i));
    tests_run++; if (full !== 1'b1 || stack_top !== 32'd16 || stack_next !== 32'd15) begin tests_failed++; $display("FAIL fill: got full=%b top=%0d next=%0d want 1 16 15", full, stack_top, stack_next); end
    do_op(0, 1, 0, 32'h99);
    tests_run++; if (overflow !== 1'b1 || stack_top !== 32'd16 || numcnt !== 6'd16 || err !== 1'b1) begin tests_failed++; $display("FAIL overflow: got ovf=%b top=%0d cnt=%0d err=%b want 1 16 16 1", overflow, stack_top, numcnt, err); end
    do_op(0, 1, 1, 32'h77);
    tests_run++; if (stack_top !== 32'h77 || numcnt !== 6'd16 || overflow !== 1'b0 || underflow !== 1'b0) begin tests_failed++; $display("FAIL replace_full: got top=%h cnt=%0d ovf=%b unf=%b want 77 16 0 0", stack_top, numcnt, overflow, underflow); end
    tests_run++; if (stack_next !== 32'd15) begin tests_failed++; $display("FAIL replace_next: got %0d want 15", stack_next); end
  endtask

  task automatic test_compute_seq;
    do_op(1, 0, 0, '0);
    do_op(0, 1, 0, 32'd5);
    do_op(0, 1, 0, 32'd3);
    do_op(0, 0, 1, '0);
    do_op(0, 0, 1, '0);
    do_op(0, 1, 0, 32'd8);
    tests_run++; if (stack_top !== 32'd8 || numcnt !== 6'd1 || stack_next !== '0) begin tests_failed++; $display("FAIL compute: got top=%0d cnt=%0d next=%h want 8 1 0", stack_top, numcnt, stack_next); end
  endtask

  task automatic test_replace_empty;
    do_op(1, 0, 0, '0);
    do_op(0, 1, 1, 32'h42);
    tests_run++; if (stack_top !== 32'h42 || numcnt !== 6'd1 || underflow !== 1'b1 || err !== 1'b1) begin tests_failed++; $display("FAIL repl_empty: got top=%h cnt=%0d unf=%b err=%b want 42 1 1 1", stack_top, numcnt, underflow, err); end
    do_op(0, 0, 0, '0);
    tests_run++; if (underflow !== 1'b0) begin tests_failed++; $display("FAIL repl_empty_pulse: got %b want 0", underflow); end
    do_op(1, 0, 0, '0);
    tests_run++; if (numcnt !== '0 || err !== 1'b0 || stack_top !== '0) begin tests_failed++; $display("FAIL clear: got cnt=%0d err=%b top=%h want 0 0 0", numcnt, err, stack_top); end
  endtask

  task automatic test_async_reset;
    do_op(1, 0, 0, '0);
    do_op(0, 1, 0, 32'hA1);
    do_op(0, 1, 0, 32'hA2);
    do_op(0, 0, 1, '0);
    do_op(0, 0, 1, '0);
    do_op(0, 0, 1, '0);
    do_op(0, 1, 0, 32'hB1);
    do_op(0, 1, 0, 32'hB2);
    do_op(0, 1, 0, 32'hB3);
    tests_run++; if (numcnt !== 6'd3 || err !== 1'b1) begin tests_failed++; $display("FAIL pre_rst: got cnt=%0d err=%b want 3 1", numcnt, err); end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests_run++; if (stack_top !== '0 || stack_next !== '0 || numcnt !== '0) begin tests_failed++; $display("FAIL async_rst_data: got %h %h %0d want 0 0 0", stack_top, stack_next, numcnt); end
    tests_run++; if ({empty, full, overflow, underflow, err} !== 5'b10000) begin tests_failed++; $display("FAIL async_rst_flags: got %b want 10000", {empty, full, overflow, underflow, err}); end
    exp_q.delete(); m_err = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_op(0, 1, 0, 32'hBEEF);
    tests_run++; if (numcnt !== 6'd1 || stack_top !== 32'hBEEF || stack_next !== '0) begin tests_failed++; $display("FAIL post_rst_push: got cnt=%0d top=%h next=%h want 1 beef 0", numcnt, stack_top, stack_next); end
  endtask

  task automatic test_random;
    logic [W-1:0] e_top, e_next;
    logic         c, p, o;
    int           push_pct;
    for (int n = 0; n < 600; n++) begin
      // Alternate push-heavy and pop-heavy phases to reach both ends.
      push_pct = ((n / 60) % 2 == 0) ? 80 : 25;
      c = ($urandom_range(0, 63) == 0);
      p = ($urandom_range(0, 99) < push_pct);
      o = ($urandom_range(0, 99) < (100 - push_pct));
      do_op(c, p, o, $urandom);
      e_top  = (exp_q.size() >= 1) ? exp_q[exp_q.size()-1] : '0;
      e_next = (exp_q.size() >= 2) ? exp_q[exp_q.size()-2] : '0;
      tests_run++;
      if (stack_top !== e_top || stack_next !== e_next || numcnt !== C'(exp_q.size()) ||
          full !== (exp_q.size() == D) || empty !== (exp_q.size() == 0) ||
          overflow !== m_ovf || underflow !== m_unf || err !== m_err) begin
        tests_failed++;
        $display("FAIL rand[%0d]: got top=%h next=%h cnt=%0d f=%b e=%b o=%b u=%b err=%b want top=%h next=%h cnt=%0d f=%b e=%b o=%b u=%b err=%b",
                 n, stack_top, stack_next, numcnt, full, empty, overflow, underflow, err,
                 e_top, e_next, exp_q.size(), exp_q.size() == D, exp_q.size() == 0, m_ovf, m_unf, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_compute_seq();
    test_replace_empty();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/calc_stack.md
# calc_stack

LIFO operand stack serving the RPN calculator controller as its push/pop responder. Accepts single-cycle push/pop strobes, stores up to DEPTH words, and continuously presents the top two entries and the occupancy count for display on HEX7..HEX0 and LEDG. Guards against overflow and underflow with pulse and sticky error flags, and supports a same-cycle push+pop replace so the controller can pop operands and push results without stalling.

## Interface
- WIDTH, 32: data word width; controller displays bits [15:0].
- DEPTH, 16: number of entries; power of two, minimum 2.
- CNTW, 6: width of numcnt; must satisfy 2**CNTW > DEPTH.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous empty-the-stack request.
- push  input  1  write data_in as the new top this cycle.
- pop  input  1  remove the current top this cycle.
- data_in  input  WIDTH  word to push.
- stack_top  output  WIDTH  current top entry, or 0 when count < 1.
- stack_next  output  WIDTH  entry below top, or 0 when count < 2.
- numcnt  output  CNTW  number of valid entries, 0..DEPTH.
- full  output  1  numcnt == DEPTH.
- empty  output  1  numcnt == 0.
- overflow  output  1  one-cycle pulse: a push was dropped.
- underflow  output  1  one-cycle pulse: a pop was dropped.
- err  output  1  sticky OR of overflow/underflow; cleared only by rst or clear.

## Operation
- Internal state: entry array mem[0..DEPTH-1], count register (CNTW bits), overflow/underflow/err registers. Top entry is mem[count-1].
- Per-cycle op, decoded from {clear, push, pop}, in priority order:
  - clear=1: count <= 0, err <= 0; push and pop are ignored; no pulses.
  - push only, not full: mem[count] <= data_in, count <= count+1.
  - push only, full: no change; overflow pulses; err set.
  - pop only, not empty: count <= count-1. The entry is not erased.
  - pop only, empty: no change; underflow pulses; err set.
  - push+pop, count >= 1 (replace): mem[count-1] <= data_in, count unchanged, no pulse. This also applies when full.
  - push+pop, count == 0: the push proceeds (mem[0] <= data_in, count <= 1); underflow pulses; err set.
  - neither: hold.
- Output gating: stack_top and stack_next are read combinationally from mem and forced to 0 when the corresponding entry is absent. Stale mem contents are never visible.
- numcnt is count, zero-extended. full and empty are combinational from count.
- Pushes and pops are level-sampled every cycle. Edge detection and key debouncing belong to the controller; a strobe held for N cycles performs N operations.

## Timing
- Reset values: count=0, overflow=0, underflow=0, err=0, so stack_top=0, stack_next=0, numcnt=0, empty=1, full=0. mem contents are unreset (don't care).
- Reset asserted mid-operation aborts the in-flight op. Outputs take their reset values immediately (asynchronously).
- Latency: an op sampled at edge k is reflected on stack_top, stack_next, numcnt, full and empty after edge k, with zero added cycles.
- overflow/underflow are registered: high for exactly the cycle following edge k, then low unless another fault occurs.
- Read-after-write: a controller that pops at edge k sees the new top in cycle k+1. This satisfies the pop-pop-compute-push sequence, which uses one cycle per step.
- No combinational path from push, pop or data_in to any output.

## Structure
- Shared package calc_pkg holds:
  - typedef enum stack_op_e {OP_NONE, OP_PUSH, OP_POP, OP_REPLACE, OP_CLEAR};
  - default WIDTH/DEPTH constants, shared with the controller.
- Sub-module stack_mem: DEPTH x WIDTH register array with one synchronous write port and two asynchronous read ports (top, next).
- calc_stack contains the op decode, the count register and the error logic.

## Test plan
- Reset, then push 0x1234 then 0x00AB -> top=0x00AB, next=0x1234, numcnt=2, empty=0.
- Pop from that state -> top=0x1234, next=0, numcnt=1. Pop again -> top=0, empty=1. A third pop -> underflow high for one cycle, err=1, numcnt=0.
- Push 1..16 (DEPTH=16) -> full=1, top=16, next=15. Push 0x99 -> overflow pulse, top stays 16, numcnt=16. Then push+pop with 0x77 -> top=0x77, numcnt=16, no pulse.
- Stack holds [5,3] (3 on top); pop, pop, push 8 on consecutive cycles -> top=8, numcnt=1, next=0.
- Push+pop on an empty stack with data 0x42 -> top=0x42, numcnt=1, underflow pulses once, err=1. Then clear -> numcnt=0, err=0, top=0.
- Assert rst asynchronously mid-cycle while numcnt=3 -> all outputs return to reset values before the next edge. The first push after release lands in entry 0 (numcnt=1).
